fetch_controller: RTL and testbench
===================================

Name: fetch_controller

Overview:
Sequences instruction fetch from the byte-addressed, combinational-read instruction memory and hands {pc, instruction} pairs to the IF/ID stage.
- Owns the program counter and drives the memory address.
- Buffers fetched words in a small FIFO so downstream stalls do not lose instructions.
- Handles branch/jump redirects with a FIFO flush.
- Stops fetching at the end of the memory image.

Parameters:
XLEN, 64, program counter and address width
DEPTH, 2, fetch buffer entries (power of two, ≥2)
IMEM_BYTES, 16, instruction memory size in bytes; fetch halts at PC ≥ IMEM_BYTES
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  clock, rising-edge
rst_n  input  1  asynchronous active-low reset
start  input  1  pulse; begins fetching from current PC when IDLE
imem_addr  output  XLEN  byte address to instruction memory (= PC)
imem_rdata  input  32  instruction word returned combinationally for imem_addr
redirect_valid  input  1  branch/jump taken this cycle
redirect_pc  input  XLEN  target PC for redirect
if_valid  output  1  head of buffer holds a valid instruction
if_instr  output  32  instruction at buffer head
if_pc  output  XLEN  PC of buffer head
id_ready  input  1  IF/ID accepts head this cycle
busy  output  1  high in RUN
halted  output  1  high in HALT
fetch_count  output  32  number of words pushed since reset, wraps at 2^32
misalign_err  output  1  see Optional Feature

Behaviour:
- Reset: asynchronous on rst_n low; asynchronous active-low, single clock clk.
  - Reset values: state=IDLE, pc=RESET_PC, FIFO count=0, rd/wr pointers=0, if_valid=0, if_instr=0, if_pc=0, busy=0, halted=0, fetch_count=0, misalign_err=0.
  - Reset mid-operation discards all buffered entries.
- imem_addr = pc at all times, combinational from the pc register.
- States:
  - IDLE: start → RUN. No fetch in IDLE.
  - RUN: fetch enabled.
    - If pc ≥ IMEM_BYTES at a clock edge with no redirect → HALT; no push that cycle.
  - HALT: no fetch. FIFO continues to drain.
  - IDLE, RUN or HALT: redirect_valid → RUN, regardless of start.
- Fetch (RUN, pc < IMEM_BYTES, no redirect), when count < DEPTH or a pop occurs the same cycle:
  - push {pc, imem_rdata}
  - pc ← pc+4
  - fetch_count+1
  - Otherwise pc holds (stall).
- Pop: if_valid && id_ready.
  - Simultaneous push and pop with a full FIFO is legal; count unchanged.
- if_valid = (count≠0). if_instr/if_pc come from the head entry, combinational from storage; 0 when empty.
- Latency: a pushed word appears on if_valid the cycle after the push edge. The first instruction is visible 2 cycles after start is sampled: one cycle to enter RUN, one to push.
- Redirect, highest priority:
  - Flush FIFO (count=0, pointers=0); pc ← redirect_pc.
  - No push and no pop that cycle. A same-cycle id_ready handshake is ignored, and the head is dropped.
  - Fetch resumes from the new pc the next cycle.
- Redirect asserted during HALT with a target < IMEM_BYTES resumes fetching. A target ≥ IMEM_BYTES → RUN, then HALT on the next edge.
- pc arithmetic is XLEN-bit unsigned and wraps silently.
- Each 32-bit word is taken as-is from imem_rdata; byte assembly is the memory's responsibility.
- start while in RUN or HALT: ignored.

Optional Feature:
Macro: FETCH_MISALIGN_CHECK_EN
- Defined:
  - A redirect with redirect_pc[1:0] ≠ 0 flushes and enters HALT instead of RUN.
  - pc still loads the target.
  - misalign_err is set; it is sticky until reset or an aligned redirect.
- Undefined:
  - redirect_pc[1:0] is forced to 00 on load.
  - misalign_err is tied 0.

Test Plan:
Bench memory holds words 0x02853483, 0x009A84B3, 0x00148493, 0x02953423 at addresses 0, 4, 8, 12.
1. Reset, start pulse, id_ready=1 → if_valid high from cycle 2. Sequence (pc, instr): (0, 0x02853483), (4, 0x009A84B3), (8, 0x00148493), (12, 0x02953423). Then halted=1, if_valid=0, fetch_count=4.
2. start, id_ready=0 for 5 cycles → count saturates at 2, imem_addr holds at 8, fetch_count=2. Release id_ready → remaining words delivered in order with no loss and no duplicates.
3. During RUN with 2 buffered entries, redirect_valid with redirect_pc=12 and id_ready=1 → FIFO empties next cycle, the head is not consumed, and the next delivered pair is (12, 0x02953423).
4. Let the block reach HALT, then redirect_pc=4 → busy=1, delivers (4, …), (8, …), (12, …), then halts again; fetch_count increments by 3.
5. Assert rst_n low mid-stream with 2 entries buffered → all outputs return to reset values immediately, without waiting for a clock edge; start re-fetches from address 0.
6. With FETCH_MISALIGN_CHECK_EN defined: redirect_pc=6 → halted=1, misalign_err=1. A subsequent redirect_pc=0 clears misalign_err and resumes. Macro undefined: the same stimulus → pc=4, misalign_err stays 0.

Source files
------------

// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - instruction fetch sequencer with fetch buffer; optional FETCH_MISALIGN_CHECK_EN
module fetch_controller #(
  parameter int              XLEN       = 64,
  parameter int              DEPTH      = 2,
  parameter int              IMEM_BYTES = 16,
  parameter logic [XLEN-1:0] RESET_PC   = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  output logic [31:0]     if_instr,
  output logic [XLEN-1:0] if_pc,
  input  logic            id_ready,
  output logic            busy,
  output logic            halted,
  output logic [31:0]     fetch_count,
  output logic            misalign_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]   DEPTH_C  = CW'(DEPTH);
  localparam logic [XLEN-1:0] IMEM_END = XLEN'(IMEM_BYTES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  logic [1:0]      state, state_nx;
  logic [XLEN-1:0] pc;
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] pc_buf    [DEPTH];
  logic [31:0]     instr_buf [DEPTH];
  logic            pop, push, in_image;
  logic [XLEN-1:0] redirect_target;
  logic            misaligned;

  assign imem_addr = pc;
  assign in_image  = (pc < IMEM_END);
  assign if_valid  = (count != '0);
  assign if_instr  = if_valid ? instr_buf[rd_ptr] : 32'd0;
  assign if_pc     = if_valid ? pc_buf[rd_ptr] : '0;
  assign busy      = (state == S_RUN);
  assign halted    = (state == S_HALT);

  // Redirect wins over everything: no handshake and no fetch in a redirect cycle.
  assign pop  = if_valid && id_ready && !redirect_valid;
  assign push = (state == S_RUN) && in_image && !redirect_valid
                && ((count < DEPTH_C) || pop);

`ifdef FETCH_MISALIGN_CHECK_EN
  assign misaligned      = |redirect_pc[1:0];
  assign redirect_target = redirect_pc;
`else
  assign misaligned      = 1'b0;
  assign redirect_target = redirect_pc & ~XLEN'(3);
`endif

  // Next-state selection; a misaligned redirect parks the fetcher in HALT.
  always_comb begin
    state_nx = state;
    if (redirect_valid) begin
      state_nx = misaligned ? S_HALT : S_RUN;
    end else begin
      case (state)
        S_IDLE:  if (start) state_nx = S_RUN;
        S_RUN:   if (!in_image) state_nx = S_HALT;
        default: state_nx = state;
      endcase
    end
  end

  // Control state: FSM, pc, buffer pointers/occupancy and the fetch counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      fetch_count <= 32'd0;
    end else begin
      state <= state_nx;
      if (redirect_valid) begin
        pc     <= redirect_target;
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          pc          <= pc + XLEN'(4);
          wr_ptr      <= wr_ptr + PW'(1);
          fetch_count <= fetch_count + 32'd1;
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Buffer payload needs no reset; occupancy gates what is visible.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_buf[wr_ptr]    <= pc;
      instr_buf[wr_ptr] <= imem_rdata;
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  // Sticky misalignment flag, refreshed by every redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign_err <= 1'b0;
    else if (redirect_valid) misalign_err <= misaligned;
  end
`else
  assign misalign_err = misaligned;
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// tb/tb_fetch_controller.sv - directed self-checking bench for fetch_controller
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [63:0] if_pc;
  logic        id_ready;
  logic        busy;
  logic        halted;
  logic [31:0] fetch_count;
  logic        misalign_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] words [4];
  logic [63:0] got_pc  [$];
  logic [31:0] got_ins [$];

  fetch_controller #(.XLEN(64), .DEPTH(2), .IMEM_BYTES(16), .RESET_PC(64'd0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .id_ready       (id_ready),
    .busy           (busy),
    .halted         (halted),
    .fetch_count    (fetch_count),
    .misalign_err   (misalign_err)
  );

  always #5 clk = ~clk;

  always_comb begin
    if (imem_addr < 64'd16) imem_rdata = words[imem_addr[3:2]];
    else imem_rdata = 32'd0;
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, act, exp);
    end
  endtask

  // One clock: record a handshake at the falling edge, then settle just after the rising edge.
  task automatic step();
    @(negedge clk);
    if (if_valid && id_ready && !redirect_valid) begin
      got_pc.push_back(if_pc);
      got_ins.push_back(if_instr);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    got_pc.delete();
    got_ins.delete();
  endtask

  task automatic run_to_halt(input int budget);
    int n = 0;
    while (!(halted && !if_valid) && n < budget) begin
      step();
      n++;
    end
    check("halt_reached", {62'd0, halted, if_valid}, 64'd2);
  endtask

  // Expect n delivered pairs starting at word index first.
  task automatic check_seq(input string tag, input int first, input int n);
    check({tag, "_len"}, 64'(got_pc.size()), 64'(n));
    for (int i = 0; i < n; i++) begin
      if (i < got_pc.size()) begin
        check({tag, "_pc"}, got_pc[i], 64'(4 * (first + i)));
        check({tag, "_ins"}, {32'd0, got_ins[i]}, {32'd0, words[first + i]});
      end
    end
    got_pc.delete();
    got_ins.delete();
  endtask

  initial begin
    words[0] = 32'h02853483;
    words[1] = 32'h009A84B3;
    words[2] = 32'h00148493;
    words[3] = 32'h02953423;
    start = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 64'd0;
    id_ready = 1'b0;
    rst_n = 1'b1;
    #2;

    // 1: reset values, then straight-through fetch
    do_reset();
    check("rst_if_valid", {63'd0, if_valid}, 64'd0);
    check("rst_if_instr", {32'd0, if_instr}, 64'd0);
    check("rst_if_pc", if_pc, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_halted", {63'd0, halted}, 64'd0);
    check("rst_fetch_count", {32'd0, fetch_count}, 64'd0);
    check("rst_misalign", {63'd0, misalign_err}, 64'd0);
    check("rst_imem_addr", imem_addr, 64'd0);
    step();
    check("idle_no_fetch", imem_addr, 64'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    id_ready = 1'b1;
    check("t1_busy", {63'd0, busy}, 64'd1);
    check("t1_cycle1_empty", {63'd0, if_valid}, 64'd0);
    step();
    check("t1_cycle2_valid", {63'd0, if_valid}, 64'd1);
    check("t1_cycle2_pc", if_pc, 64'd0);
    run_to_halt(20);
    check_seq("t1", 0, 4);
    check("t1_fetch_count", {32'd0, fetch_count}, 64'd4);
    start = 1'b1;
    step();
    start = 1'b0;
    check("t1_start_in_halt", {63'd0, halted}, 64'd1);

    // 2: downstream stall fills the buffer, then drains without loss
    do_reset();
    id_ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("t2_addr_hold", imem_addr, 64'd8);
    check("t2_fetch_count", {32'd0, fetch_count}, 64'd2);
    check("t2_head_pc", if_pc, 64'd0);
    id_ready = 1'b1;
    run_to_halt(20);
    check_seq("t2", 0, 4);

    // 3: redirect with a full buffer flushes and drops the head
    do_reset();
    id_ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    check("t3_full_count", {32'd0, fetch_count}, 64'd2);
    id_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 64'd12;
    step();
    redirect_valid = 1'b0;
    check("t3_flushed", {63'd0, if_valid}, 64'd0);
    check("t3_new_pc", imem_addr, 64'd12);
    check("t3_no_pop", 64'(got_pc.size()), 64'd0);
    run_to_halt(20);
    check_seq("t3", 3, 1);
    check("t3_fetch_count", {32'd0, fetch_count}, 64'd3);

    // 4: redirect out of HALT resumes, then halts again
    redirect_valid = 1'b1;
    redirect_pc = 64'd4;
    step();
    redirect_valid = 1'b0;
    check("t4_busy", {63'd0, busy}, 64'd1);
    run_to_halt(20);
    check_seq("t4", 1, 3);
    check("t4_fetch_count", {32'd0, fetch_count}, 64'd6);
    redirect_valid = 1'b1;
    redirect_pc = 64'd20;
    step();
    redirect_valid = 1'b0;
    check("t4_oob_run", {63'd0, busy}, 64'd1);
    step();
    check("t4_oob_halt", {63'd0, halted}, 64'd1);
    check("t4_oob_count", {32'd0, fetch_count}, 64'd6);

    // 5: asynchronous reset mid-stream
    do_reset();
    id_ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    check("t5_if_valid", {63'd0, if_valid}, 64'd0);
    check("t5_busy", {63'd0, busy}, 64'd0);
    check("t5_addr", imem_addr, 64'd0);
    check("t5_fetch_count", {32'd0, fetch_count}, 64'd0);
    check("t5_if_pc", if_pc, 64'd0);
    #1;
    rst_n = 1'b1;
    got_pc.delete();
    got_ins.delete();
    start = 1'b1;
    step();
    start = 1'b0;
    id_ready = 1'b1;
    run_to_halt(20);
    check_seq("t5", 0, 4);

    // 6: misaligned redirect
    redirect_valid = 1'b1;
    redirect_pc = 64'd6;
    step();
    redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    check("t6_halted", {63'd0, halted}, 64'd1);
    check("t6_misalign", {63'd0, misalign_err}, 64'd1);
    check("t6_pc", imem_addr, 64'd6);
    step();
    check("t6_sticky", {63'd0, misalign_err}, 64'd1);
    redirect_valid = 1'b1;
    redirect_pc = 64'd0;
    step();
    redirect_valid = 1'b0;
    check("t6_cleared", {63'd0, misalign_err}, 64'd0);
    check("t6_resume", {63'd0, busy}, 64'd1);
    got_pc.delete();
    got_ins.delete();
    run_to_halt(20);
    check_seq("t6", 0, 4);
`else
    check("t6_pc", imem_addr, 64'd4);
    check("t6_misalign", {63'd0, misalign_err}, 64'd0);
    check("t6_busy", {63'd0, busy}, 64'd1);
    got_pc.delete();
    got_ins.delete();
    run_to_halt(20);
    check_seq("t6", 1, 3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
